pifo_pop_collector: RTL and testbench

PIFO_POP_COLLECTOR -- requirements
Module: pifo_pop_collector

---
 rtl/pifo_pop_collector.sv | 138 +++++++++++++
 tb/tb_pifo_pop_collector.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_pop_collector.sv
// Collects pop responses from LEVEL PIFO units into per-level FIFOs, then merges them round-robin into one registered output.
// Optional build macro PIFO_POP_SENTINEL_FILTER_EN drops all-ones (empty-PIFO sentinel) responses at the FIFO input.
module pifo_pop_collector #(
  parameter int PTW       = 16,
  parameter int MTW       = 0,
  parameter int CTW       = 10,
  parameter int LEVEL     = 4,
  parameter int TREE_NUM  = 4,
  parameter int RSP_DEPTH = 4,
  localparam int W  = MTW + PTW,
  localparam int TB = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [LEVEL-1:0]      i_lvl_valid,
  input  logic [LEVEL*W-1:0]    i_lvl_data,
  input  logic [LEVEL*TB-1:0]   i_lvl_tree_id,
  output logic [LEVEL-1:0]      o_lvl_afull,
  output logic                  o_valid,
  output logic [W-1:0]          o_data,
  output logic [TB-1:0]         o_tree_id,
  input  logic                  i_ready,
  output logic [LEVEL-1:0]      o_overflow,
  output logic [CTW-1:0]        o_pop_cnt
);

  localparam int AW = $clog2(RSP_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TB + W;
  localparam int LW = (LEVEL > 1) ? $clog2(LEVEL) : 1;

  logic [EW-1:0]    mem_q    [LEVEL][RSP_DEPTH];
  logic [AW-1:0]    wr_ptr_q [LEVEL];
  logic [AW-1:0]    rd_ptr_q [LEVEL];
  logic [CW-1:0]    cnt_q    [LEVEL];
  logic [LW-1:0]    rr_q;
  logic             out_vld_q;
  logic [W-1:0]     out_data_q;
  logic [TB-1:0]    out_tid_q;
  logic [LEVEL-1:0] ovf_q;
  logic [CTW-1:0]   pop_cnt_q;

  logic             grant_vld;
  logic [LW-1:0]    grant_lvl;
  logic             ld, xfer;
  logic [LEVEL-1:0] rd, wr_req, wr, ovf_ev;
  logic [EW-1:0]    rd_entry;

  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant_lvl = '0;
    idx       = 0;
    for (int unsigned k = 0; k < LEVEL; k++) begin
      idx = (32'(rr_q) + k) % LEVEL;
      if (!grant_vld && cnt_q[LW'(idx)] != '0) begin
        grant_vld = 1'b1;
        grant_lvl = LW'(idx);
      end
    end
  end

  assign xfer     = out_vld_q && i_ready;
  assign ld       = grant_vld && (!out_vld_q || i_ready);
  assign rd_entry = mem_q[grant_lvl][rd_ptr_q[grant_lvl]];

  // A full FIFO still accepts a write when it is being read in the same cycle.
  always_comb begin
    rd     = '0;
    wr_req = '0;
    wr     = '0;
    ovf_ev = '0;
    for (int unsigned l = 0; l < LEVEL; l++) begin
      rd[l] = ld && (grant_lvl == LW'(l));
`ifdef PIFO_POP_SENTINEL_FILTER_EN
      wr_req[l] = i_lvl_valid[l] && (i_lvl_data[l*W +: W] != '1);
`else
      wr_req[l] = i_lvl_valid[l];
`endif
      wr[l]     = wr_req[l] && ((cnt_q[l] != CW'(RSP_DEPTH)) || rd[l]);
      ovf_ev[l] = wr_req[l] && (cnt_q[l] == CW'(RSP_DEPTH)) && !rd[l];
    end
  end

  always_ff @(posedge i_clk) begin
    for (int unsigned l = 0; l < LEVEL; l++) begin
      if (!i_rst && wr[l])
        mem_q[l][wr_ptr_q[l]] <= {i_lvl_tree_id[l*TB +: TB], i_lvl_data[l*W +: W]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_q       <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_tid_q  <= '0;
      ovf_q      <= '0;
      pop_cnt_q  <= '0;
      for (int unsigned l = 0; l < LEVEL; l++) begin
        wr_ptr_q[l] <= '0;
        rd_ptr_q[l] <= '0;
        cnt_q[l]    <= '0;
      end
    end else begin
      if (ld) begin
        out_vld_q               <= 1'b1;
        {out_tid_q, out_data_q} <= rd_entry;
        rr_q <= (grant_lvl == LW'(LEVEL - 1)) ? '0 : grant_lvl + LW'(1);
      end else if (xfer) begin
        out_vld_q <= 1'b0;
      end
      if (xfer)
        pop_cnt_q <= pop_cnt_q + CTW'(1);
      ovf_q <= ovf_q | ovf_ev;
      for (int unsigned l = 0; l < LEVEL; l++) begin
        if (wr[l])
          wr_ptr_q[l] <= wr_ptr_q[l] + AW'(1);
        if (rd[l])
          rd_ptr_q[l] <= rd_ptr_q[l] + AW'(1);
        cnt_q[l] <= cnt_q[l] + CW'(wr[l]) - CW'(rd[l]);
      end
    end
  end

  always_comb begin
    o_lvl_afull = '0;
    for (int unsigned l = 0; l < LEVEL; l++)
      o_lvl_afull[l] = (cnt_q[l] >= CW'(RSP_DEPTH - 1));
  end

  assign o_valid    = out_vld_q;
  assign o_data     = out_data_q;
  assign o_tree_id  = out_tid_q;
  assign o_overflow = ovf_q;
  assign o_pop_cnt  = pop_cnt_q;

endmodule

// File: tb/tb_pifo_pop_collector.sv
// Scoreboard bench for pifo_pop_collector with default parameters (PTW=16, MTW=0, LEVEL=4, TREE_NUM=4, RSP_DEPTH=4, CTW=10).
module tb_pifo_pop_collector;

  localparam int PTW = 16, MTW = 0, CTW = 10, LEVEL = 4, TREE_NUM = 4, RSP_DEPTH = 4;
  localparam int W = PTW + MTW;
  localparam int TB = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [LEVEL-1:0]     lvl_valid;
  logic [LEVEL*W-1:0]   lvl_data;
  logic [LEVEL*TB-1:0]  lvl_tid;
  logic [LEVEL-1:0]     lvl_afull;
  logic                 valid;
  logic [W-1:0]         data;
  logic [TB-1:0]        tid;
  logic                 ready;
  logic [LEVEL-1:0]     overflow;
  logic [CTW-1:0]       pop_cnt;

  logic [TB+W-1:0] sb_q[$];
  logic [TB+W-1:0] exp_e;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pifo_pop_collector #(
    .PTW(PTW), .MTW(MTW), .CTW(CTW), .LEVEL(LEVEL), .TREE_NUM(TREE_NUM), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_lvl_valid(lvl_valid), .i_lvl_data(lvl_data),
    .i_lvl_tree_id(lvl_tid), .o_lvl_afull(lvl_afull), .o_valid(valid), .o_data(data),
    .o_tree_id(tid), .i_ready(ready), .o_overflow(overflow), .o_pop_cnt(pop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int lvl, input logic [W-1:0] d, input logic [TB-1:0] t, input bit expect_out);
    lvl_valid[lvl]        = 1'b1;
    lvl_data[lvl*W +: W]  = d;
    lvl_tid[lvl*TB +: TB] = t;
    if (expect_out) sb_q.push_back({t, d});
  endtask

  task automatic clear_strobes();
    lvl_valid = '0;
    lvl_data  = '0;
    lvl_tid   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_strobes();
    tick();
    tick();
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ready = 1'b1;
    strobe(0, 16'h0AAA, 2'd1, 1'b0);
    strobe(3, 16'h0BBB, 2'd2, 1'b0);
    tick();
    tick();
    clear_strobes();
    rst = 1'b0;
    n_vec++;
    if ({valid, data, tid, overflow, pop_cnt, lvl_afull} !== '0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b data=%h tid=%h ovf=%b cnt=%0d afull=%b, required all zero",
               valid, data, tid, overflow, pop_cnt, lvl_afull);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_strobe_ignored: valid=%b, required 0", valid);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    ready = 1'b1;
    strobe(2, 16'h1234, 2'd2, 1'b1);
    tick();
    clear_strobes();
    n_vec++;
    if (valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_latency_early: valid=%b, required 0", valid);
    end
    tick();
    exp_e = sb_q.pop_front();
    n_vec++;
    if (valid !== 1'b1 || {tid, data} !== exp_e) begin
      n_err++;
      $display("FAIL single_out: valid=%b tid/data=%h, required 1 %h", valid, {tid, data}, exp_e);
    end
    tick();
    n_vec++;
    if (pop_cnt !== 10'd1 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_popcnt: cnt=%0d valid=%b, required 1 0", pop_cnt, valid);
    end
  endtask

  task automatic test_fairness();
    int cyc[$];
    do_reset();
    ready = 1'b1;
    for (int l = 0; l < LEVEL; l++) strobe(l, 16'hA000 + 16'(l), 2'(l), 1'b1);
    tick();
    clear_strobes();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (valid && ready) begin
        exp_e = sb_q.pop_front();
        cyc.push_back(c);
        n_vec++;
        if ({tid, data} !== exp_e) begin
          n_err++;
          $display("FAIL fair_order: got %h, required %h", {tid, data}, exp_e);
        end
      end
      tick();
    end
    n_vec++;
    if (cyc.size() != 4 || sb_q.size() != 0 || cyc[3] - cyc[0] != 3) begin
      n_err++;
      $display("FAIL fair_consecutive: transfers=%0d left=%0d, required 4 consecutive 0 left", cyc.size(), sb_q.size());
    end
    // rr should be back at 0: levels 3 and 0 together must come out 0 first
    strobe(3, 16'hB003, 2'd3, 1'b0);
    strobe(0, 16'hB000, 2'd0, 1'b0);
    sb_q.push_back({2'd0, 16'hB000});
    sb_q.push_back({2'd3, 16'hB003});
    tick();
    clear_strobes();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid && ready) begin
        exp_e = sb_q.pop_front();
        n_vec++;
        if ({tid, data} !== exp_e) begin
          n_err++;
          $display("FAIL fair_rr_wrap: got %h, required %h", {tid, data}, exp_e);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit exp_afull[6] = '{0, 0, 0, 1, 1, 1};
    bit exp_ovf[6]   = '{0, 0, 0, 0, 0, 1};
    int got = 0;
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      clear_strobes();
      strobe(1, 16'h0100 + 16'(i), 2'd1, i < 5);
      tick();
      n_vec++;
      if (lvl_afull[1] !== exp_afull[i] || overflow[1] !== exp_ovf[i]) begin
        n_err++;
        $display("FAIL bp_flags[%0d]: afull=%b ovf=%b, required %b %b", i, lvl_afull[1], overflow[1], exp_afull[i], exp_ovf[i]);
      end
    end
    clear_strobes();
    tick();
    n_vec++;
    if (valid !== 1'b1 || data !== 16'h0100) begin
      n_err++;
      $display("FAIL bp_hold: valid=%b data=%h, required 1 0100", valid, data);
    end
    ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (valid && ready) begin
        got++;
        exp_e = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
        n_vec++;
        if ({tid, data} !== exp_e) begin
          n_err++;
          $display("FAIL bp_drain: got %h, required %h", {tid, data}, exp_e);
        end
      end
      tick();
    end
    n_vec++;
    if (got != 5 || overflow[1] !== 1'b1 || pop_cnt !== 10'd5) begin
      n_err++;
      $display("FAIL bp_final: delivered=%0d ovf=%b cnt=%0d, required 5 1 5", got, overflow[1], pop_cnt);
    end
  endtask

  task automatic test_full_read();
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      clear_strobes();
      strobe(0, 16'h0200 + 16'(i), 2'd3, 1'b1);
      tick();
    end
    clear_strobes();
    tick();
    ready = 1'b1;
    strobe(0, 16'h02FF, 2'd0, 1'b1);
    tick();
    clear_strobes();
    ready = 1'b0;
    n_vec++;
    if (overflow !== '0 || lvl_afull[0] !== 1'b1 || data !== 16'h0201) begin
      n_err++;
      $display("FAIL fullrd_flags: ovf=%b afull0=%b data=%h, required 0000 1 0201", overflow, lvl_afull[0], data);
    end
    sb_q.pop_front();
    ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (valid && ready) begin
        exp_e = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
        n_vec++;
        if ({tid, data} !== exp_e) begin
          n_err++;
          $display("FAIL fullrd_drain: got %h, required %h", {tid, data}, exp_e);
        end
      end
      tick();
    end
    n_vec++;
    if (sb_q.size() != 0 || pop_cnt !== 10'd6) begin
      n_err++;
      $display("FAIL fullrd_count: left=%0d cnt=%0d, required 0 6", sb_q.size(), pop_cnt);
    end
  endtask

  task automatic test_sentinel();
    int got = 0;
    do_reset();
    ready = 1'b1;
`ifdef PIFO_POP_SENTINEL_FILTER_EN
    strobe(3, 16'hFFFF, 2'd3, 1'b0);
`else
    strobe(3, 16'hFFFF, 2'd3, 1'b1);
`endif
    tick();
    clear_strobes();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (valid && ready) begin
        got++;
        exp_e = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
        n_vec++;
        if ({tid, data} !== exp_e) begin
          n_err++;
          $display("FAIL sentinel_out: got %h, required %h", {tid, data}, exp_e);
        end
      end
      tick();
    end
    n_vec++;
    if (sb_q.size() != 0 || 32'(pop_cnt) != got || overflow !== '0) begin
      n_err++;
      $display("FAIL sentinel_count: left=%0d cnt=%0d ovf=%b, required 0 %0d 0000", sb_q.size(), pop_cnt, overflow, got);
    end
  endtask

  task automatic test_midreset();
    do_reset();
    ready = 1'b0;
    for (int l = 0; l < 3; l++) strobe(l, 16'h0300 + 16'(l), 2'(l), 1'b0);
    tick();
    clear_strobes();
    tick();
    n_vec++;
    if (valid !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre: valid=%b, required 1", valid);
    end
    rst = 1'b1;
    ready = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (valid !== 1'b0 || pop_cnt !== '0 || lvl_afull !== '0) begin
      n_err++;
      $display("FAIL midrst_post: valid=%b cnt=%0d afull=%b, required 0 0 0000", valid, pop_cnt, lvl_afull);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      n_vec++;
      if (valid !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_leak: valid=%b data=%h, required 0", valid, data);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 1030;
    int got = 0;
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < N + 20; c++) begin
      clear_strobes();
      if (c < N) strobe(c % LEVEL, 16'($urandom_range(0, 16'hFFFE)), 2'($urandom), 1'b1);
      @(negedge clk);
      if (valid && ready) begin
        got++;
        exp_e = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
        n_vec++;
        if ({tid, data} !== exp_e) begin
          n_err++;
          $display("FAIL b2b_data[%0d]: got %h, required %h", got, {tid, data}, exp_e);
        end
      end
      tick();
    end
    clear_strobes();
    n_vec++;
    if (got != N || pop_cnt !== CTW'(N % (1 << CTW)) || overflow !== '0) begin
      n_err++;
      $display("FAIL b2b_wrap: delivered=%0d cnt=%0d ovf=%b, required %0d %0d 0000", got, pop_cnt, overflow, N, N % (1 << CTW));
    end
  endtask

  initial begin
    rst   = 1'b1;
    ready = 1'b0;
    clear_strobes();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_full_read();
    test_sentinel();
    test_midreset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
